// File: rtl/alu_mdu_ctrl.sv
// ALU operation decoder with an iterative multiply/divide unit (one bit per cycle).
// Define MDU_DIV_EN to build DIV/DIVU/REM/REMU; otherwise only multiplies are supported.
module alu_mdu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic            Itype,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      Operation,
  output logic            stall_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result,
  output logic            illegal_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_p_q, neg_p_d;
  logic [XLEN-1:0]   res_q, res_d;
`ifdef MDU_DIV_EN
  logic              neg_r_q, neg_r_d;
  logic              div_zero_s, div_ovf_s;
  logic [XLEN:0]     div_sh_s, div_tr_s;
`endif

  logic              f7_zero_s, f7_sub_s, f7_m_s;
  logic              mop_raw_s, mop_s, accept_s;
  logic              fast_s;
  logic [XLEN-1:0]   fast_res_s;
  logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN-1:0]   acc_step_s, lo_step_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   final_res_s;

  assign f7_zero_s = (Funct7 == 7'b0000000);
  assign f7_sub_s  = (Funct7 == 7'b0100000);
  assign f7_m_s    = (Funct7 == 7'b0000001);
  assign mop_raw_s = (ALUOp == 2'b10) && !Itype && f7_m_s;
`ifdef MDU_DIV_EN
  assign mop_s     = mop_raw_s;
`else
  assign mop_s     = mop_raw_s && !Funct3[2];
`endif
  assign accept_s  = (state_q == S_IDLE) && valid_i && mop_s;

  // M-ops that are decoded but not built (divides without the divider) also count as illegal.
  assign illegal_o = valid_i && (((ALUOp == 2'b10) && !Itype && !(f7_zero_s || f7_sub_s || f7_m_s))
                              || (f7_sub_s && (Funct3 != 3'b000) && (Funct3 != 3'b101))
                              || (mop_raw_s && !mop_s));

  assign stall_o     = !reset && (((state_q == S_IDLE) && valid_i && mop_s) || (state_q == S_BUSY));
  assign mdu_valid_o = (state_q == S_DONE);
  assign mdu_result  = res_q;

  // ALU operation select from ALUOp/Funct3/Funct7.
  always_comb begin
    Operation = OP_ADD;
    case (ALUOp)
      2'b00: Operation = OP_ADD;
      2'b01: begin
        case (Funct3[2:1])
          2'b00:   Operation = OP_EQ;
          2'b10:   Operation = OP_SLT;
          2'b11:   Operation = OP_SLTU;
          default: Operation = OP_EQ;
        endcase
      end
      2'b10: begin
        if (mop_raw_s) begin
          Operation = OP_ADD;
        end else begin
          case (Funct3)
            3'b000:  Operation = (!Itype && f7_sub_s) ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = f7_sub_s ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            3'b111:  Operation = OP_AND;
            default: Operation = OP_ADD;
          endcase
        end
      end
      2'b11:   Operation = OP_PASS;
      default: Operation = OP_ADD;
    endcase
  end

  // Operand signedness and magnitudes; the engine always works on magnitudes.
  always_comb begin
    a_signed_s = Funct3[2] ? !Funct3[0] : ((Funct3[1:0] == 2'b01) || (Funct3[1:0] == 2'b10));
    b_signed_s = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01);
    a_neg_s    = a_signed_s && op_a[XLEN-1];
    b_neg_s    = b_signed_s && op_b[XLEN-1];
    a_mag_s    = a_neg_s ? -op_a : op_a;
    b_mag_s    = b_neg_s ? -op_b : op_b;
  end

`ifdef MDU_DIV_EN
  // Divide-by-zero and signed-overflow results bypass the iterative engine.
  always_comb begin
    div_zero_s = (op_b == {XLEN{1'b0}});
    div_ovf_s  = !Funct3[0] && (op_a == MOST_NEG) && (op_b == ALL_ONES);
    fast_s     = Funct3[2] && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      fast_res_s = Funct3[1] ? op_a : ALL_ONES;
    end else if (div_ovf_s) begin
      fast_res_s = Funct3[1] ? {XLEN{1'b0}} : op_a;
    end else begin
      fast_res_s = {XLEN{1'b0}};
    end
  end
`else
  assign fast_s     = 1'b0;
  assign fast_res_s = {XLEN{1'b0}};
`endif

  // One engine step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    acc_step_s = mul_sum_s[XLEN:1];
    lo_step_s  = {mul_sum_s[0], lo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    div_sh_s = {acc_q, lo_q[XLEN-1]};
    div_tr_s = div_sh_s - {1'b0, mcand_q};
    if (f3_q[2]) begin
      if (!div_tr_s[XLEN]) begin
        acc_step_s = div_tr_s[XLEN-1:0];
        lo_step_s  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step_s = div_sh_s[XLEN-1:0];
        lo_step_s  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step_s = mul_sum_s[XLEN:1];
    end
`endif
  end

  // Sign fix-up and result selection on the final step.
  always_comb begin
    prod_s     = {acc_step_s, lo_step_s};
    prod_fix_s = neg_p_q ? -prod_s : prod_s;
    case (f3_q)
      3'b000:                final_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res_s = prod_fix_s[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
      3'b100:                final_res_s = neg_p_q ? -lo_step_s : lo_step_s;
      3'b101:                final_res_s = lo_step_s;
      3'b110:                final_res_s = neg_r_q ? -acc_step_s : acc_step_s;
      3'b111:                final_res_s = acc_step_s;
`endif
      default:               final_res_s = prod_fix_s[XLEN-1:0];
    endcase
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    f3_d    = f3_q;
    neg_p_d = neg_p_q;
    res_d   = res_q;
`ifdef MDU_DIV_EN
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          acc_d   = {XLEN{1'b0}};
          lo_d    = a_mag_s;
          mcand_d = b_mag_s;
          f3_d    = Funct3;
          neg_p_d = a_neg_s ^ b_neg_s;
`ifdef MDU_DIV_EN
          neg_r_d = a_neg_s;
`endif
          cnt_d   = {CW{1'b0}};
          if (fast_s) begin
            state_d = S_DONE;
            res_d   = fast_res_s;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = acc_step_s;
        lo_d  = lo_step_s;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_DONE;
          cnt_d   = {CW{1'b0}};
          res_d   = final_res_s;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      mcand_q <= {XLEN{1'b0}};
      f3_q    <= 3'b000;
      neg_p_q <= 1'b0;
      res_q   <= {XLEN{1'b0}};
`ifdef MDU_DIV_EN
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      f3_q    <= f3_d;
      neg_p_q <= neg_p_d;
      res_q   <= res_d;
`ifdef MDU_DIV_EN
      neg_r_q <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Bench for alu_mdu_ctrl: decode table, directed multiply/divide sequences, reset abort, random M-ops.
module tb_alu_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [1:0]  ALUOp;
  logic        Itype;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  Operation;
  logic        stall_o;
  logic        mdu_valid_o;
  logic [31:0] mdu_result;
  logic        illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ALUOp(ALUOp), .Itype(Itype),
    .Funct7(Funct7), .Funct3(Funct3), .op_a(op_a), .op_b(op_b),
    .Operation(Operation), .stall_o(stall_o), .mdu_valid_o(mdu_valid_o),
    .mdu_result(mdu_result), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] aluop;
    logic       it;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       ill;
  } dvec_t;

  dvec_t tbl [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural result of an M-op, straight from the instruction definitions.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] ps, psu;
    logic signed [31:0] sa, sb, sq;
    logic [31:0]        r;
    logic               ovf;
    pu  = {32'd0, a} * {32'd0, b};
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    psu = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    r   = 32'd0;
    case (f3)
      3'd0: r = pu[31:0];
      3'd1: r = ps[63:32];
      3'd2: r = psu[63:32];
      3'd3: r = pu[63:32];
      3'd4: if (b == 32'd0) r = 32'hFFFFFFFF; else if (ovf) r = a; else begin sq = sa / sb; r = sq; end
      3'd5: if (b == 32'd0) r = 32'hFFFFFFFF; else r = a / b;
      3'd6: if (b == 32'd0) r = a; else if (ovf) r = 32'd0; else begin sq = sa % sb; r = sq; end
      default: if (b == 32'd0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && ((b == 32'd0) || (!f3[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF))))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; ALUOp = 2'b10; Itype = 1'b0; Funct7 = 7'b0000001;
    Funct3 = f3; op_a = a; op_b = b;
  endtask

  // Entered at a negedge in IDLE with an M-op applied; ends one negedge after DONE.
  task automatic run_mop(input string name, input logic [31:0] exp_res, input int exp_lat,
                         input bit chain, input logic [2:0] cf3, input logic [31:0] ca, input logic [31:0] cb);
    int k;
    int stalls;
    bit seen;
    #1;
    check({name, " accept stall"}, 64'(stall_o), 64'd1);
    check({name, " operation"}, 64'(Operation), 64'd2);
    check({name, " illegal"}, 64'(illegal_o), 64'd0);
    @(posedge clk);
    #1 valid_i = 1'b0;
    stalls = 1;
    seen   = 1'b0;
    k      = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (mdu_valid_o) seen = 1'b1;
      else if (stall_o) stalls++;
    end
    check({name, " latency"}, 64'(k), 64'(exp_lat));
    check({name, " stall cycles"}, 64'(stalls), 64'(exp_lat));
    check({name, " result"}, 64'(mdu_result), 64'(exp_res));
    if (chain) apply_mop(cf3, ca, cb);
    #1;
    check({name, " stall in done"}, 64'(stall_o), 64'd0);
    @(negedge clk);
    check({name, " valid pulse"}, 64'(mdu_valid_o), 64'd0);
    check({name, " result held"}, 64'(mdu_result), 64'(exp_res));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          pulses;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 7'h20, 3'b000, 4'b0110, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 1'b1, 7'h20, 3'b000, 4'b0010, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b101, 4'b0101, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 1'b1, 7'h20, 3'b101, 4'b0111, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 1'b0, 7'h20, 3'b101, 4'b0111, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b001, 4'b0100, 1'b0};
    tbl[6]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b010, 4'b1001, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b011, 4'b1011, 1'b0};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b100, 4'b0011, 1'b0};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b110, 4'b0001, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 7'h00, 3'b111, 4'b0000, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 1'b0, 7'h00, 3'b010, 4'b0010, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 7'h00, 3'b000, 4'b1010, 1'b0};
    tbl[13] = '{1'b1, 2'b01, 1'b0, 7'h00, 3'b001, 4'b1000, 1'b0};
    tbl[14] = '{1'b1, 2'b01, 1'b0, 7'h00, 3'b100, 4'b1001, 1'b0};
    tbl[15] = '{1'b1, 2'b01, 1'b0, 7'h00, 3'b111, 4'b1011, 1'b0};
    tbl[16] = '{1'b1, 2'b10, 1'b0, 7'h04, 3'b000, 4'b0010, 1'b1};
    tbl[17] = '{1'b1, 2'b10, 1'b0, 7'h20, 3'b110, 4'b0001, 1'b1};
    tbl[18] = '{1'b0, 2'b10, 1'b0, 7'h04, 3'b000, 4'b0010, 1'b0};
    tbl[19] = '{1'b1, 2'b00, 1'b0, 7'h20, 3'b010, 4'b0010, 1'b1};
    tbl[20] = '{1'b1, 2'b10, 1'b1, 7'h2A, 3'b011, 4'b1011, 1'b0};
    tbl[21] = '{1'b1, 2'b10, 1'b1, 7'h00, 3'b001, 4'b0100, 1'b0};

    reset = 1'b0; valid_i = 1'b0; ALUOp = 2'b00; Itype = 1'b0;
    Funct7 = 7'd0; Funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset valid", 64'(mdu_valid_o), 64'd0);
    check("reset result", 64'(mdu_result), 64'd0);
    apply_mop(3'b000, 32'd1, 32'd1);
    #1 check("reset stall with mop", 64'(stall_o), 64'd0);
    @(negedge clk);
    check("reset holds idle", 64'(mdu_valid_o), 64'd0);
    valid_i = 1'b0;
    reset   = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      valid_i = tbl[i].v; ALUOp = tbl[i].aluop; Itype = tbl[i].it;
      Funct7 = tbl[i].f7; Funct3 = tbl[i].f3;
      #1;
      check($sformatf("decode[%0d] operation", i), 64'(Operation), 64'(tbl[i].op));
      check($sformatf("decode[%0d] illegal", i), 64'(illegal_o), 64'(tbl[i].ill));
      check($sformatf("decode[%0d] no stall", i), 64'(stall_o), 64'd0);
    end
    valid_i = 1'b0;

    @(negedge clk);
    apply_mop(3'b000, 32'd7, 32'hFFFFFFFD);
    run_mop("mul 7*-3", 32'hFFFFFFEB, 33, 1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mop("mulhu", 32'hFFFFFFFE, 33, 1'b0, 3'b000, 32'd0, 32'd0);
    apply_mop(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mop("mulh", 32'h00000000, 33, 1'b0, 3'b000, 32'd0, 32'd0);

`ifdef MDU_DIV_EN
    apply_mop(3'b100, 32'hFFFFFFF9, 32'd2);
    run_mop("div -7/2", 32'hFFFFFFFD, 33, 1'b0, 3'b000, 32'd0, 32'd0);
    apply_mop(3'b110, 32'hFFFFFFF9, 32'd2);
    run_mop("rem -7%2", 32'hFFFFFFFF, 33, 1'b0, 3'b000, 32'd0, 32'd0);
    apply_mop(3'b101, 32'd12345, 32'd0);
    run_mop("divu by zero", 32'hFFFFFFFF, 1, 1'b0, 3'b000, 32'd0, 32'd0);
    apply_mop(3'b100, 32'h80000000, 32'hFFFFFFFF);
    run_mop("div overflow", 32'h80000000, 1, 1'b0, 3'b000, 32'd0, 32'd0);
`else
    for (int i = 4; i < 8; i++) begin
      apply_mop(3'(i), 32'hFFFFFFF9, 32'd2);
      #1;
      check($sformatf("nodiv f3=%0d illegal", i), 64'(illegal_o), 64'd1);
      check($sformatf("nodiv f3=%0d stall", i), 64'(stall_o), 64'd0);
      @(posedge clk);
      #1 valid_i = 1'b0;
      @(negedge clk);
      check($sformatf("nodiv f3=%0d not accepted", i), 64'(stall_o), 64'd0);
    end
`endif

    // Abort in the middle of a multiply.
    apply_mop(3'b000, 32'd5, 32'd9);
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort stall", 64'(stall_o), 64'd0);
    check("abort valid", 64'(mdu_valid_o), 64'd0);
    check("abort result", 64'(mdu_result), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu_valid_o || stall_o) pulses++;
    end
    check("abort no pulse", 64'(pulses), 64'd0);
    apply_mop(3'b000, 32'd3, 32'd4);
    run_mop("mul after abort", 32'd12, 33, 1'b0, 3'b000, 32'd0, 32'd0);

    for (int i = 0; i < 24; i++) begin
`ifdef MDU_DIV_EN
      f3 = 3'($urandom_range(0, 7));
`else
      f3 = 3'($urandom_range(0, 3));
`endif
      a = pick();
      b = pick();
      apply_mop(f3, a, b);
      run_mop($sformatf("rand[%0d] f3=%0d a=%0h b=%0h", i, f3, a, b),
              ref_mdu(f3, a, b), ref_lat(f3, a, b), 1'b0, 3'b000, 32'd0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
